// File: rtl/reservoir_stream.sv
// Time-delay reservoir: a shift chain of virtual nodes closed into a feedback loop
// through an external nonlinearity, with valid/ready streaming on both sides.
module reservoir_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_NODES  = 64,
   parameter int NODE_CNT_W = $clog2(MAX_NODES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [NODE_CNT_W-1:0] cfg_num_nodes,
   input  logic [3:0]            cfg_fb_shift,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic [DATA_WIDTH-1:0] nl_in,
   input  logic [DATA_WIDTH-1:0] nl_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy
);

   localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NL   = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] node_q [MAX_NODES];
   logic [DATA_WIDTH-1:0] node_d [MAX_NODES];
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d;

   logic [NODE_CNT_W-1:0] ne;
   logic [IDX_W-1:0]      tap_idx;
   logic [DATA_WIDTH-1:0] tap;
   logic [DATA_WIDTH-1:0] fb;
   logic [DATA_WIDTH:0]   add_full;
   logic [DATA_WIDTH-1:0] sum_sat;
   logic                  accept;

   // Feedback path: clamp loop length, pick the oldest active node, attenuate, saturating add.
   always_comb begin
      ne = cfg_num_nodes;
      if (cfg_num_nodes == '0) begin
         ne = NODE_CNT_W'(1);
      end else if (cfg_num_nodes > NODE_CNT_W'(MAX_NODES)) begin
         ne = NODE_CNT_W'(MAX_NODES);
      end
      tap_idx  = IDX_W'(ne - NODE_CNT_W'(1));
      tap      = node_q[tap_idx];
      fb       = tap >> cfg_fb_shift;
      add_full = {1'b0, s_data} + {1'b0, fb};
      sum_sat  = add_full[DATA_WIDTH] ? '1 : add_full[DATA_WIDTH-1:0];
   end

   assign s_ready = (state_q == IDLE) && !clear;
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d   = state_q;
      node_d    = node_q;
      sum_d     = sum_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sum_d   = sum_sat;
               state_d = NL;
            end
         end
         NL: begin
            node_d[0] = nl_out;
            for (int i = 1; i < MAX_NODES; i++) begin
               node_d[i] = node_q[i-1];
            end
            m_data_d  = nl_out;
            m_valid_d = 1'b1;
            state_d   = OUT;
         end
         OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Clear drops any in-flight sample; m_data keeps its last value.
      if (clear) begin
         for (int i = 0; i < MAX_NODES; i++) begin
            node_d[i] = '0;
         end
         sum_d     = '0;
         m_valid_d = 1'b0;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sum_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         for (int i = 0; i < MAX_NODES; i++) begin
            node_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         node_q    <= node_d;
      end
   end

   assign nl_in   = sum_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reservoir_stream.sv
// Scoreboard bench for reservoir_stream with an identity nonlinearity (nl_out = nl_in)
// and a reduced node count so the loop-length clamp is reachable quickly.
module tb_reservoir_stream;

   localparam int DW = 32;
   localparam int MN = 8;
   localparam int CW = $clog2(MN + 1);

   logic          clk;
   logic          rst;
   logic          clear;
   logic [CW-1:0] cfg_num_nodes;
   logic [3:0]    cfg_fb_shift;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [DW-1:0] nl_in;
   logic [DW-1:0] nl_out;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          busy;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] exp_q[$];

   reservoir_stream #(
      .DATA_WIDTH(DW),
      .MAX_NODES (MN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .cfg_num_nodes(cfg_num_nodes),
      .cfg_fb_shift (cfg_fb_shift),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .nl_in        (nl_in),
      .nl_out       (nl_out),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .busy         (busy)
   );

   assign nl_out = nl_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every output handshake pops and compares one scoreboard entry.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", m_data, '0);
            if (m_data === '0) begin
               errors++;
               $display("[TB] FAIL unexpected_output: got output with empty scoreboard, required none");
            end
         end else begin
            checkOutput("m_data", m_data, exp_q.pop_front());
         end
      end
   end

   task automatic applyStimulus(input logic [DW-1:0] data, input logic [CW-1:0] n,
                                input logic [3:0] sh, input logic [DW-1:0] expected,
                                input bit push);
      int t = 0;
      @(negedge clk);
      s_valid       = 1'b1;
      s_data        = data;
      cfg_num_nodes = n;
      cfg_fb_shift  = sh;
      while (!s_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checkOutput("s_ready_timeout", 32'(s_ready), 32'd1);
      end
      if (push) exp_q.push_back(expected);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checkOutput("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic doClear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      checkOutput("s_ready_in_clear", 32'(s_ready), 32'd0);
      clear = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] held;
      int            t;

      rst           = 1'b1;
      clear         = 1'b0;
      cfg_num_nodes = '0;
      cfg_fb_shift  = '0;
      s_valid       = 1'b0;
      s_data        = '0;
      m_ready       = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_data", m_data, '0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_nl_in", nl_in, '0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("s_ready_after_rst", 32'(s_ready), 32'd1);

      $display("[TB] N=1 shift=0 feedback");
      applyStimulus(32'd5, CW'(1), 4'd0, 32'd5, 1'b1);
      applyStimulus(32'd3, CW'(1), 4'd0, 32'd8, 1'b1);
      waitDrain();
      doClear();

      $display("[TB] N=3 delay loop");
      applyStimulus(32'd1, CW'(3), 4'd0, 32'd1, 1'b1);
      applyStimulus(32'd2, CW'(3), 4'd0, 32'd2, 1'b1);
      applyStimulus(32'd3, CW'(3), 4'd0, 32'd3, 1'b1);
      applyStimulus(32'd4, CW'(3), 4'd0, 32'd5, 1'b1);
      waitDrain();
      doClear();

      $display("[TB] N=1 shift=1 attenuation");
      applyStimulus(32'd8, CW'(1), 4'd1, 32'd8, 1'b1);
      applyStimulus(32'd0, CW'(1), 4'd1, 32'd4, 1'b1);
      applyStimulus(32'd0, CW'(1), 4'd1, 32'd2, 1'b1);
      waitDrain();
      doClear();

      $display("[TB] saturation");
      applyStimulus(32'hFFFF_FFF0, CW'(1), 4'd0, 32'hFFFF_FFF0, 1'b1);
      applyStimulus(32'h0000_0020, CW'(1), 4'd0, 32'hFFFF_FFFF, 1'b1);
      waitDrain();
      doClear();

      $display("[TB] backpressure");
      @(posedge clk);
      #1 m_ready = 1'b0;
      applyStimulus(32'd42, CW'(1), 4'd0, 32'd42, 1'b1);
      t = 0;
      while (!m_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      checkOutput("bp_m_valid_rise", 32'(m_valid), 32'd1);
      held = m_data;
      checkOutput("bp_m_data", held, 32'd42);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_hold_valid", 32'(m_valid), 32'd1);
         checkOutput("bp_hold_data", m_data, held);
         checkOutput("bp_s_ready", 32'(s_ready), 32'd0);
      end
      @(posedge clk);
      #1 m_ready = 1'b1;
      @(posedge clk);
      #1 checkOutput("bp_release_s_ready", 32'(s_ready), 32'd1);
      waitDrain();
      doClear();

      $display("[TB] clear during NL");
      applyStimulus(32'd99, CW'(1), 4'd0, '0, 1'b0);
      checkOutput("nl_busy", 32'(busy), 32'd1);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("cleared_m_valid", 32'(m_valid), 32'd0);
      end
      checkOutput("cleared_busy", 32'(busy), 32'd0);
      applyStimulus(32'd7, CW'(1), 4'd0, 32'd7, 1'b1);
      waitDrain();
      doClear();

      $display("[TB] cfg_num_nodes=0 behaves as N=1");
      applyStimulus(32'd5, CW'(0), 4'd0, 32'd5, 1'b1);
      applyStimulus(32'd3, CW'(0), 4'd0, 32'd8, 1'b1);
      waitDrain();
      doClear();

      $display("[TB] cfg_num_nodes above MAX_NODES clamps");
      for (int i = 1; i <= MN; i++) begin
         applyStimulus(DW'(i), CW'(MN + 5), 4'd0, DW'(i), 1'b1);
      end
      applyStimulus(DW'(MN + 1), CW'(MN + 5), 4'd0, DW'(MN + 2), 1'b1);
      waitDrain();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] timeout");
   end

endmodule
